// File: rtl/mont_precomp.sv
// rtl/mont_precomp.sv - Montgomery constant precompute: n0' = -N^-1 mod 2^DW, R mod N, R^2 mod N
module mont_precomp #(
  parameter int NW = 256,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] VN,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [NW-1:0] VNI,
  output logic [NW-1:0] VR1,
  output logic [NW-1:0] VR2
);

  localparam int CW = $clog2(2 * NW);
  localparam int IW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [NW-1:0] r_n;
  logic [NW:0]   r_x;
  logic [DW-1:0] r_y;
  logic [CW-1:0] r_cnt;

  logic [NW:0]   w_t;
  logic [NW:0]   w_nx;
  logic [NW:0]   w_xn;
  logic [DW-1:0] w_prod;
  logic [IW-1:0] w_i;
  logic          w_hensel;
  logic [DW-1:0] w_bit;
  logic [DW-1:0] w_nip;
  logic          w_vn_ok;

  // Doubling step: x stays below N, so 2x needs at most one subtraction of N.
  assign w_t  = r_x << 1;
  assign w_nx = {1'b0, r_n};
  assign w_xn = (w_t >= w_nx) ? (w_t - w_nx) : w_t;

  // Hensel lifting: fix bit i of y whenever bit i of N*y is still set.
  assign w_prod   = r_n[DW-1:0] * r_y;
  assign w_i      = r_cnt[IW-1:0] + IW'(1);
  assign w_hensel = (r_cnt < CW'(DW - 1)) && w_prod[w_i];
  assign w_bit    = DW'(1) << w_i;
  assign w_nip    = ~r_y + DW'(1);

  // An odd modulus greater than one is the only one with a Montgomery inverse.
  assign w_vn_ok = VN[0] & (|VN[NW-1:1]);

  // Control FSM with doubling/Hensel datapath and registered result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      VNI     <= '0;
      VR1     <= '0;
      VR2     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_n   <= VN;
            r_x   <= (NW + 1)'(1);
            r_y   <= DW'(1);
            r_cnt <= '0;
            busy  <= 1'b1;
            if (w_vn_ok) begin
              err     <= 1'b0;
              r_state <= S_RUN;
            end else begin
              err     <= 1'b1;
              VNI     <= '0;
              VR1     <= '0;
              VR2     <= '0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_x   <= w_xn;
          r_cnt <= r_cnt + CW'(1);
          if (w_hensel) begin
            r_y <= r_y + w_bit;
          end
          if (r_cnt == CW'(NW - 1)) begin
            VR1 <= w_xn[NW-1:0];
          end
          if (r_cnt == CW'(2 * NW - 1)) begin
            VR2     <= w_xn[NW-1:0];
            VNI     <= {{(NW - DW){1'b0}}, w_nip};
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
